cache_line_fill_engine: RTL and testbench
=========================================

Name: cache_line_fill_engine

Overview:
- Parametrised L1 miss handler. Accepts one read or write miss, optionally writes the store word through to L2, then fetches the full line from L2 one word per granted request.
- Supports critical-word-first ordering, merges the store word into the returned line, and presents the line plus a valid tag to the L1 array as a single-cycle fill pulse.
- Sits between the L1 data cache controller and the L2 bus arbiter.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, L2 word width; power of two, >= 8.
- WORDS_PER_LINE, 8, words per cache line; power of two, >= 2.
- TAG_W, 18, tag width; tag = miss_addr[ADDR_W-1 -: TAG_W].
- CRIT_WORD_FIRST, 1, 1 = start the fetch at the missed word and wrap; 0 = start at word 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- miss_valid  in  1  miss request.
- miss_is_wr  in  1  1 = write miss.
- miss_addr  in  ADDR_W  miss byte address.
- miss_wr_data  in  DATA_W  store data for a write miss.
- miss_ready  out  1  engine idle; miss accepted when miss_valid & miss_ready.
- l2_req_valid  out  1  L2 request.
- l2_req_ready  in  1  arbiter grant for the current request.
- l2_req_we  out  1  1 = write.
- l2_req_addr  out  ADDR_W  word-aligned byte address.
- l2_req_wdata  out  DATA_W  write data.
- l2_rsp_valid  in  1  read data valid; responses return in request order, latency >= 1.
- l2_rsp_data  in  DATA_W  read data.
- fill_valid  out  1  one-cycle line-update pulse.
- fill_data  out  WORDS_PER_LINE*DATA_W  line data; word i at bits [i*DATA_W +: DATA_W].
- fill_tag_vld  out  TAG_W+1  {1'b1, tag}.
- fill_addr  out  ADDR_W  line-aligned address of the filled line.
- busy  out  1  state != IDLE.

Behaviour:
- Reset rst_n, synchronous, active-low; clock clk.
- Reset values: state IDLE, all counters 0, line buffer 0. Outputs: fill_valid=0, l2_req_valid=0, l2_req_we=0, l2_req_wdata=0, busy=0, miss_ready=1.
- Local widths: OFF_W = clog2(WORDS_PER_LINE), BYTE_W = clog2(DATA_W/8).
- On acceptance, register the following:
  - line address (miss_addr with low OFF_W+BYTE_W bits zeroed);
  - word offset off = miss_addr[BYTE_W +: OFF_W];
  - is_wr and wr_data;
  - start = CRIT_WORD_FIRST ? off : 0.
- FSM states: IDLE, WRITE, READ, FILL.
  - IDLE: on accept, go to WRITE if is_wr, else READ.
  - WRITE: drive l2_req_valid=1, we=1, addr = {line, off, BYTE_W'0}, wdata = wr_data; hold all of these until l2_req_ready; then go to READ.
  - READ: l2_req_valid=1 while issue_cnt < WORDS_PER_LINE; we=0; addr uses word index (start + issue_cnt) mod WORDS_PER_LINE. issue_cnt increments on valid & ready. rsp_cnt increments on each l2_rsp_valid, and the data is written to slot (start + rsp_cnt) mod WORDS_PER_LINE. If is_wr and that slot == off, store wr_data instead of rsp data (merge). When the last response is captured (rsp_cnt == WORDS_PER_LINE-1 & l2_rsp_valid), go to FILL.
  - FILL: fill_valid=1 for exactly one cycle, with fill_data, fill_tag_vld and fill_addr stable; next state IDLE.
- Timing: miss_ready is combinational (state==IDLE), so back-to-back misses are accepted the cycle after FILL. l2_rsp_valid outside READ is ignored.
- Boundaries:
  - Offset wrap-around is modulo WORDS_PER_LINE.
  - The count compares use OFF_W+1-bit counters, so there is no overflow at full line.
  - A response arriving in the same cycle as a grant updates both counters.
  - Any miss_valid while not idle is ignored; the requester holds it.
- Minimum read-miss latency, with ready=1 and fixed response latency L: accept cycle + WORDS_PER_LINE-1+L cycles to the last response, then fill_valid the next cycle. A write miss adds 1 cycle (the write grant).
- Reset mid-operation: return to IDLE immediately, with no fill_valid. Responses still in flight after reset are ignored because the state is IDLE.

Decomposition:
- Shared package cache_pkg: fill_state_e enum {IDLE, WRITE, READ, FILL}, and the line/tag width helper functions.
- One sub-module, line_fill_buffer: WORDS_PER_LINE x DATA_W register array with indexed write, merge mux and flattened read-out.

Test Plan:
- Read miss, addr 0x0000_1234, defaults, ready=1, L=2.
  - L2 addresses 0x1234, 0x1238, 0x123C, 0x1220…0x1230 (word 5 first).
  - rsp data 0xA0+slot; fill_data word i = 0xA0+i.
  - fill_tag_vld = {1, 18'h0}, fill_addr = 0x1220.
- Write miss, addr 0x0000_4008, data 0xDEADBEEF.
  - One write to 0x4008 first, then 8 reads.
  - fill word 2 = 0xDEADBEEF regardless of the L2 rsp; fill_tag_vld = {1, 18'h1}.
- CRIT_WORD_FIRST=0, WORDS_PER_LINE=4, DATA_W=64, read miss 0x58 → reads 0x40, 0x48, 0x50, 0x58; fill_addr = 0x40.
- l2_req_ready toggling 1,0,0,1…: each address is held while ungranted, no request is dropped or duplicated, exactly 8 grants occur, and fill_valid pulses once.
- Second miss_valid asserted during READ → miss_ready=0 and no effect; it is accepted the cycle after fill_valid.
- rst_n low for 1 cycle after 3 responses, then 5 stray responses → no fill_valid, state IDLE, miss_ready=1.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_pkg : shared types and width helpers for the L1 line-fill engine
// Rev 1.0
// ---------------------------------------------------------------------------
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      FILL  = 2'd3
   } fill_state_e;

   function automatic int off_width(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int byte_width(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic int line_width(input int words_per_line, input int data_w);
      return words_per_line * data_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_fill_engine_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_line_fill_engine_if : miss, L2 and fill-port bundle of the fill engine
// Rev 1.0
// ---------------------------------------------------------------------------
interface cache_line_fill_engine_if #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int WORDS_PER_LINE = 8,
   parameter int TAG_W          = 18
);
   logic                             miss_valid;
   logic                             miss_is_wr;
   logic [ADDR_W-1:0]                miss_addr;
   logic [DATA_W-1:0]                miss_wr_data;
   logic                             miss_ready;
   logic                             l2_req_valid;
   logic                             l2_req_ready;
   logic                             l2_req_we;
   logic [ADDR_W-1:0]                l2_req_addr;
   logic [DATA_W-1:0]                l2_req_wdata;
   logic                             l2_rsp_valid;
   logic [DATA_W-1:0]                l2_rsp_data;
   logic                             fill_valid;
   logic [WORDS_PER_LINE*DATA_W-1:0] fill_data;
   logic [TAG_W:0]                   fill_tag_vld;
   logic [ADDR_W-1:0]                fill_addr;
   logic                             busy;

   // master is the engine itself; slave is the L1 controller / L2 arbiter side
   modport master (
      input  miss_valid, miss_is_wr, miss_addr, miss_wr_data,
      input  l2_req_ready, l2_rsp_valid, l2_rsp_data,
      output miss_ready, l2_req_valid, l2_req_we, l2_req_addr, l2_req_wdata,
      output fill_valid, fill_data, fill_tag_vld, fill_addr, busy
   );

   modport slave (
      output miss_valid, miss_is_wr, miss_addr, miss_wr_data,
      output l2_req_ready, l2_rsp_valid, l2_rsp_data,
      input  miss_ready, l2_req_valid, l2_req_we, l2_req_addr, l2_req_wdata,
      input  fill_valid, fill_data, fill_tag_vld, fill_addr, busy
   );

endinterface
`default_nettype wire

// File: rtl/cache_line_fill_engine_line_fill_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_fill_buffer : line register array with store-word merge and flat read-out
// Rev 1.0
// ---------------------------------------------------------------------------
module line_fill_buffer
   import cache_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int WORDS_PER_LINE = 8,
   parameter int IDX_W          = 3
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             wr_en,
   input  logic [IDX_W-1:0]                 wr_idx,
   input  logic [DATA_W-1:0]                rsp_data,
   input  logic                             merge_en,
   input  logic [DATA_W-1:0]                merge_data,
   output logic [WORDS_PER_LINE*DATA_W-1:0] line
);
   logic [DATA_W-1:0] r_mem [WORDS_PER_LINE];
   logic [DATA_W-1:0] w_wr_word;

   // the pending store word takes precedence over stale L2 data in its slot
   assign w_wr_word = merge_en ? merge_data : rsp_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < WORDS_PER_LINE; i++) begin
            r_mem[i] <= '0;
         end
      end else if (wr_en) begin
         r_mem[wr_idx] <= w_wr_word;
      end
   end

   generate
      for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_flat
         assign line[g*DATA_W +: DATA_W] = r_mem[g];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/cache_line_fill_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_line_fill_engine : L1 miss handler with write-through, wrapped line fetch and fill pulse
// Rev 1.0
// ---------------------------------------------------------------------------
module cache_line_fill_engine
   import cache_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int WORDS_PER_LINE  = 8,
   parameter int TAG_W           = 18,
   parameter int CRIT_WORD_FIRST = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   cache_line_fill_engine_if.master bus
);
   localparam int c_OFF_W  = off_width(WORDS_PER_LINE);
   localparam int c_BYTE_W = byte_width(DATA_W);
   localparam int c_CNT_W  = c_OFF_W + 1;
   localparam logic [c_CNT_W-1:0] c_WORDS     = c_CNT_W'(WORDS_PER_LINE);
   localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(WORDS_PER_LINE - 1);
   localparam logic [ADDR_W-1:0]  c_LINE_MASK = {ADDR_W{1'b1}} << (c_OFF_W + c_BYTE_W);

   fill_state_e          r_state;
   logic [ADDR_W-1:0]    r_line_addr;
   logic [c_OFF_W-1:0]   r_off;
   logic [c_OFF_W-1:0]   r_start;
   logic                 r_is_wr;
   logic [DATA_W-1:0]    r_wr_data;
   logic [c_CNT_W-1:0]   r_issue_cnt;
   logic [c_CNT_W-1:0]   r_rsp_cnt;
   logic                 r_req_valid;
   logic                 r_req_we;
   logic [ADDR_W-1:0]    r_req_addr;
   logic [DATA_W-1:0]    r_req_wdata;
   logic                 r_fill_valid;

   logic                 w_accept;
   logic                 w_grant;
   logic                 w_rsp_take;
   logic                 w_merge;
   logic [ADDR_W-1:0]    w_miss_line;
   logic [c_OFF_W-1:0]   w_miss_off;
   logic [c_OFF_W-1:0]   w_miss_start;
   logic [c_CNT_W-1:0]   w_issue_nxt;
   logic [c_OFF_W-1:0]   w_issue_idx;
   logic [c_OFF_W-1:0]   w_rsp_idx;
   logic [WORDS_PER_LINE*DATA_W-1:0] w_line;

   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] line_addr,
                                                   input logic [c_OFF_W-1:0] idx);
      logic [ADDR_W-1:0] a;
      a = line_addr;
      a[c_BYTE_W +: c_OFF_W] = idx;
      return a;
   endfunction

   assign w_accept     = bus.miss_valid && (r_state == IDLE);
   assign w_grant      = r_req_valid && bus.l2_req_ready;
   assign w_rsp_take   = (r_state == READ) && bus.l2_rsp_valid;
   assign w_miss_line  = bus.miss_addr & c_LINE_MASK;
   assign w_miss_off   = bus.miss_addr[c_BYTE_W +: c_OFF_W];
   assign w_miss_start = (CRIT_WORD_FIRST != 0) ? w_miss_off : '0;
   assign w_issue_nxt  = r_issue_cnt + c_CNT_W'(1);
   // slot indices wrap naturally by truncating to the offset width
   assign w_issue_idx  = r_start + w_issue_nxt[c_OFF_W-1:0];
   assign w_rsp_idx    = r_start + r_rsp_cnt[c_OFF_W-1:0];
   assign w_merge      = r_is_wr && (w_rsp_idx == r_off);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_line_addr  <= '0;
         r_off        <= '0;
         r_start      <= '0;
         r_is_wr      <= 1'b0;
         r_wr_data    <= '0;
         r_issue_cnt  <= '0;
         r_rsp_cnt    <= '0;
         r_req_valid  <= 1'b0;
         r_req_we     <= 1'b0;
         r_req_addr   <= '0;
         r_req_wdata  <= '0;
         r_fill_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_line_addr <= w_miss_line;
                  r_off       <= w_miss_off;
                  r_start     <= w_miss_start;
                  r_is_wr     <= bus.miss_is_wr;
                  r_wr_data   <= bus.miss_wr_data;
                  r_issue_cnt <= '0;
                  r_rsp_cnt   <= '0;
                  r_req_valid <= 1'b1;
                  if (bus.miss_is_wr) begin
                     r_state     <= WRITE;
                     r_req_we    <= 1'b1;
                     r_req_addr  <= word_addr(w_miss_line, w_miss_off);
                     r_req_wdata <= bus.miss_wr_data;
                  end else begin
                     r_state     <= READ;
                     r_req_we    <= 1'b0;
                     r_req_addr  <= word_addr(w_miss_line, w_miss_start);
                  end
               end
            end
            WRITE: begin
               if (w_grant) begin
                  r_state     <= READ;
                  r_req_we    <= 1'b0;
                  r_req_wdata <= '0;
                  r_req_addr  <= word_addr(r_line_addr, r_start);
               end
            end
            READ: begin
               if (w_grant) begin
                  r_issue_cnt <= w_issue_nxt;
                  if (w_issue_nxt == c_WORDS) begin
                     r_req_valid <= 1'b0;
                  end else begin
                     r_req_addr  <= word_addr(r_line_addr, w_issue_idx);
                  end
               end
               if (w_rsp_take) begin
                  r_rsp_cnt <= r_rsp_cnt + c_CNT_W'(1);
                  if (r_rsp_cnt == c_LAST) begin
                     r_state      <= FILL;
                     r_fill_valid <= 1'b1;
                     r_req_valid  <= 1'b0;
                  end
               end
            end
            FILL: begin
               r_fill_valid <= 1'b0;
               r_state      <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   line_fill_buffer #(
      .DATA_W         (DATA_W),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .IDX_W          (c_OFF_W)
   ) u_line_fill_buffer (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (w_rsp_take),
      .wr_idx     (w_rsp_idx),
      .rsp_data   (bus.l2_rsp_data),
      .merge_en   (w_merge),
      .merge_data (r_wr_data),
      .line       (w_line)
   );

   assign bus.miss_ready   = (r_state == IDLE);
   assign bus.busy         = (r_state != IDLE);
   assign bus.l2_req_valid = r_req_valid;
   assign bus.l2_req_we    = r_req_we;
   assign bus.l2_req_addr  = r_req_addr;
   assign bus.l2_req_wdata = r_req_wdata;
   assign bus.fill_valid   = r_fill_valid;
   assign bus.fill_data    = w_line;
   assign bus.fill_tag_vld = {1'b1, r_line_addr[ADDR_W-1 -: TAG_W]};
   assign bus.fill_addr    = r_line_addr;

endmodule
`default_nettype wire

// File: tb/tb_cache_line_fill_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cache_line_fill_engine : randomized L2 responder against a line-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cache_line_fill_engine;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic [255:0] data;
      logic [18:0]  tag;
      logic [31:0]  addr;
   } fill_t;

   typedef struct {
      int          due;
      logic [31:0] data;
   } rsp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cache_line_fill_engine_if #(.ADDR_W(32), .DATA_W(32), .WORDS_PER_LINE(8), .TAG_W(18)) bus_a ();
   cache_line_fill_engine_if #(.ADDR_W(32), .DATA_W(64), .WORDS_PER_LINE(4), .TAG_W(18)) bus_b ();

   cache_line_fill_engine #(
      .ADDR_W(32), .DATA_W(32), .WORDS_PER_LINE(8), .TAG_W(18), .CRIT_WORD_FIRST(1)
   ) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

   cache_line_fill_engine #(
      .ADDR_W(32), .DATA_W(64), .WORDS_PER_LINE(4), .TAG_W(18), .CRIT_WORD_FIRST(0)
   ) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   int n_vec  = 0;
   int n_miss = 0;

   req_t  exp_req[$], obs_req[$];
   fill_t exp_fill[$], obs_fill[$];
   rsp_t  pend[$];
   int    cyc = 0, lat = 2, rdy_mode = 0, stray = 0, n_rsp = 0, tog = 0;
   int    hold_err = 0, accept_cyc = 0, fill_cyc = 0;
   bit    pat_mode = 1'b0;
   logic [31:0] salt = 32'h0;

   logic [31:0]  b_addr_q[$];
   logic [31:0]  b_last_addr = '0;
   logic [255:0] b_fill_data = '0;
   logic [31:0]  b_fill_addr = '0;
   logic [18:0]  b_fill_tag = '0;
   int           b_fills = 0;

   task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // L2 backing store contents as seen by the responder and the model alike
   function automatic logic [31:0] l2_word(input logic [31:0] addr);
      if (pat_mode) return 32'hA0 + {29'd0, addr[4:2]};
      return (addr * 32'h9E37_79B1) ^ salt;
   endfunction

   task automatic model_miss(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] line;
      int          off;
      req_t        r;
      fill_t       f;
      line = addr & 32'hFFFF_FFE0;
      off  = int'(addr[4:2]);
      if (is_wr) begin
         r.we = 1'b1; r.addr = line + 32'(off * 4); r.wdata = wdata;
         exp_req.push_back(r);
      end
      for (int k = 0; k < 8; k++) begin
         r.we = 1'b0; r.addr = line + 32'(((off + k) % 8) * 4); r.wdata = '0;
         exp_req.push_back(r);
      end
      for (int i = 0; i < 8; i++) begin
         f.data[i*32 +: 32] = (is_wr && i == off) ? wdata : l2_word(line + 32'(i * 4));
      end
      f.tag  = {1'b1, addr[31:14]};
      f.addr = line;
      exp_fill.push_back(f);
   endtask

   // responder / monitor for the default-configuration engine
   initial begin : bfm_a
      req_t  r;
      fill_t f;
      rsp_t  p;
      bit    was_stalled;
      logic [31:0] stalled_addr;
      was_stalled = 1'b0;
      stalled_addr = '0;
      bus_a.l2_req_ready = 1'b0;
      bus_a.l2_rsp_valid = 1'b0;
      bus_a.l2_rsp_data  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (was_stalled && rst_n &&
             !(bus_a.l2_req_valid && bus_a.l2_req_addr == stalled_addr)) hold_err++;
         was_stalled  = rst_n && bus_a.l2_req_valid && !bus_a.l2_req_ready;
         stalled_addr = bus_a.l2_req_addr;
         if (bus_a.l2_req_valid && bus_a.l2_req_ready) begin
            r.we    = bus_a.l2_req_we;
            r.addr  = bus_a.l2_req_addr;
            r.wdata = bus_a.l2_req_we ? bus_a.l2_req_wdata : 32'h0;
            obs_req.push_back(r);
            if (!bus_a.l2_req_we) begin
               p.due = cyc + lat; p.data = l2_word(bus_a.l2_req_addr);
               pend.push_back(p);
            end
         end
         if (bus_a.fill_valid) begin
            f.data = bus_a.fill_data; f.tag = bus_a.fill_tag_vld; f.addr = bus_a.fill_addr;
            obs_fill.push_back(f);
            fill_cyc = cyc;
         end
         if (bus_a.miss_valid && bus_a.miss_ready) accept_cyc = cyc;
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus_a.l2_req_ready = 1'b1;
            1:       begin bus_a.l2_req_ready = (tog % 3 == 0); tog++; end
            default: bus_a.l2_req_ready = 1'($urandom_range(0, 1));
         endcase
         if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
            p = pend.pop_front();
            bus_a.l2_rsp_valid = 1'b1; bus_a.l2_rsp_data = p.data;
            n_rsp++;
         end else if (stray > 0) begin
            stray--;
            bus_a.l2_rsp_valid = 1'b1; bus_a.l2_rsp_data = $urandom;
         end else begin
            bus_a.l2_rsp_valid = 1'b0;
         end
      end
   end

   // always-ready, latency-1 responder for the 4x64 engine
   initial begin : bfm_b
      bit fire;
      bus_b.l2_req_ready = 1'b1;
      bus_b.l2_rsp_valid = 1'b0;
      bus_b.l2_rsp_data  = '0;
      forever begin
         @(negedge clk);
         fire = bus_b.l2_req_valid;
         if (fire) begin
            b_addr_q.push_back(bus_b.l2_req_addr);
            b_last_addr = bus_b.l2_req_addr;
         end
         if (bus_b.fill_valid) begin
            b_fill_data = bus_b.fill_data; b_fill_addr = bus_b.fill_addr;
            b_fill_tag = bus_b.fill_tag_vld; b_fills++;
         end
         @(posedge clk);
         #1;
         bus_b.l2_rsp_valid = fire;
         bus_b.l2_rsp_data  = {32'hB0B0_0000, b_last_addr};
      end
   end

   task automatic issue_miss(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata);
      bit ok;
      ok = 1'b0;
      @(posedge clk);
      #1;
      bus_a.miss_valid = 1'b1; bus_a.miss_is_wr = is_wr;
      bus_a.miss_addr = addr; bus_a.miss_wr_data = wdata;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (bus_a.miss_ready) begin ok = 1'b1; break; end
      end
      check_val("accept", 256'(ok), 256'(1));
      @(posedge clk);
      #1;
      bus_a.miss_valid = 1'b0;
   endtask

   task automatic wait_fills(input int n);
      for (int t = 0; t < 600 && obs_fill.size() < n; t++) @(negedge clk);
      repeat (6) @(negedge clk);
      check_val("fill_seen", 256'(obs_fill.size() >= n), 256'(1));
   endtask

   task automatic compare_all(input string tag);
      int n;
      check_val({tag, "/nreq"}, 256'(obs_req.size()), 256'(exp_req.size()));
      n = (obs_req.size() < exp_req.size()) ? obs_req.size() : exp_req.size();
      for (int i = 0; i < n; i++)
         check_val($sformatf("%s/req%0d", tag, i), 256'(obs_req[i]), 256'(exp_req[i]));
      check_val({tag, "/nfill"}, 256'(obs_fill.size()), 256'(exp_fill.size()));
      n = (obs_fill.size() < exp_fill.size()) ? obs_fill.size() : exp_fill.size();
      for (int i = 0; i < n; i++) begin
         check_val($sformatf("%s/fdata%0d", tag, i), obs_fill[i].data, exp_fill[i].data);
         check_val($sformatf("%s/ftag%0d", tag, i), 256'(obs_fill[i].tag), 256'(exp_fill[i].tag));
         check_val($sformatf("%s/faddr%0d", tag, i), 256'(obs_fill[i].addr), 256'(exp_fill[i].addr));
      end
      check_val({tag, "/hold"}, 256'(hold_err), 256'(0));
      check_val({tag, "/idle"}, 256'({bus_a.busy, bus_a.miss_ready}), 256'(2'b01));
      obs_req.delete(); exp_req.delete(); obs_fill.delete(); exp_fill.delete();
      hold_err = 0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "simulation timeout");
   end

   initial begin : main
      logic [31:0] a, d, a2, d2;
      bit          w, ok;
      int          base;
      bus_a.miss_valid = 1'b0; bus_a.miss_is_wr = 1'b0; bus_a.miss_addr = '0; bus_a.miss_wr_data = '0;
      bus_b.miss_valid = 1'b0; bus_b.miss_is_wr = 1'b0; bus_b.miss_addr = '0; bus_b.miss_wr_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst/ready", 256'(bus_a.miss_ready), 256'(1));
      check_val("rst/busy", 256'(bus_a.busy), 256'(0));
      check_val("rst/fill", 256'(bus_a.fill_valid), 256'(0));
      check_val("rst/req", 256'({bus_a.l2_req_valid, bus_a.l2_req_we}), 256'(0));
      check_val("rst/wdata", 256'(bus_a.l2_req_wdata), 256'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // critical-word-first read with the 0xA0+slot data pattern
      pat_mode = 1'b1; lat = 2; rdy_mode = 0;
      model_miss(1'b0, 32'h0000_1234, 32'h0);
      issue_miss(1'b0, 32'h0000_1234, 32'h0);
      wait_fills(1);
      compare_all("rd1234");

      pat_mode = 1'b0; salt = $urandom; lat = 3;
      model_miss(1'b1, 32'h0000_4008, 32'hDEAD_BEEF);
      issue_miss(1'b1, 32'h0000_4008, 32'hDEAD_BEEF);
      wait_fills(1);
      compare_all("wr4008");

      // grant pattern 1,0,0,1,... holds each request for two idle cycles
      rdy_mode = 1; tog = 0; lat = 1; a = $urandom;
      model_miss(1'b0, a, 32'h0);
      issue_miss(1'b0, a, 32'h0);
      wait_fills(1);
      compare_all("toggle");

      rdy_mode = 2;
      for (int k = 0; k < 6; k++) begin
         salt = $urandom; lat = $urandom_range(1, 4);
         w = 1'($urandom_range(0, 1)); a = $urandom; d = $urandom;
         model_miss(w, a, d);
         issue_miss(w, a, d);
         wait_fills(1);
         compare_all($sformatf("rand%0d", k));
      end

      // second miss held during READ must wait for the first fill
      rdy_mode = 0; lat = 2; salt = $urandom;
      a = $urandom; a2 = $urandom; d2 = $urandom;
      model_miss(1'b0, a, 32'h0);
      model_miss(1'b1, a2, d2);
      issue_miss(1'b0, a, 32'h0);
      for (int t = 0; t < 100 && obs_req.size() < 2; t++) @(negedge clk);
      @(posedge clk);
      #1;
      bus_a.miss_valid = 1'b1; bus_a.miss_is_wr = 1'b1; bus_a.miss_addr = a2; bus_a.miss_wr_data = d2;
      @(negedge clk);
      check_val("b2b/ready_low", 256'(bus_a.miss_ready), 256'(0));
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (bus_a.miss_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk);
      #1;
      bus_a.miss_valid = 1'b0;
      check_val("b2b/accepted", 256'(ok), 256'(1));
      check_val("b2b/accept_cyc", 256'(accept_cyc), 256'(fill_cyc + 1));
      check_val("b2b/one_fill", 256'(obs_fill.size()), 256'(1));
      wait_fills(2);
      compare_all("b2b");

      // reset after three responses, then stray responses
      salt = $urandom; lat = 2; base = n_rsp; a = $urandom;
      issue_miss(1'b0, a, 32'h0);
      for (int t = 0; t < 100 && n_rsp < base + 3; t++) @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      stray = 5;
      repeat (12) @(negedge clk);
      check_val("rstmid/nofill", 256'(obs_fill.size()), 256'(0));
      check_val("rstmid/ready", 256'(bus_a.miss_ready), 256'(1));
      check_val("rstmid/busy", 256'(bus_a.busy), 256'(0));
      check_val("rstmid/reqv", 256'(bus_a.l2_req_valid), 256'(0));
      obs_req.delete(); obs_fill.delete(); hold_err = 0;

      salt = $urandom; a = $urandom; d = $urandom;
      model_miss(1'b1, a, d);
      issue_miss(1'b1, a, d);
      wait_fills(1);
      compare_all("recover");

      // 4 x 64-bit line, fetch from word 0
      @(posedge clk);
      #1;
      bus_b.miss_valid = 1'b1; bus_b.miss_is_wr = 1'b0; bus_b.miss_addr = 32'h58;
      @(negedge clk);
      check_val("b/ready", 256'(bus_b.miss_ready), 256'(1));
      @(posedge clk);
      #1;
      bus_b.miss_valid = 1'b0;
      for (int t = 0; t < 60 && b_fills < 1; t++) @(negedge clk);
      check_val("b/nfill", 256'(b_fills), 256'(1));
      check_val("b/nreq", 256'(b_addr_q.size()), 256'(4));
      for (int i = 0; i < 4 && i < b_addr_q.size(); i++)
         check_val($sformatf("b/req%0d", i), 256'(b_addr_q[i]), 256'(32'h40 + 32'(i * 8)));
      for (int i = 0; i < 4; i++)
         check_val($sformatf("b/word%0d", i), 256'(b_fill_data[i*64 +: 64]),
                   256'({32'hB0B0_0000, 32'h40 + 32'(i * 8)}));
      check_val("b/faddr", 256'(b_fill_addr), 256'(32'h40));
      check_val("b/ftag", 256'(b_fill_tag), 256'(19'h40000));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
